// File: rtl/seq_mult.sv
// seq_mult: shift-add unsigned multiplier, one partial product per clock, start/busy/done handshake
module seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, WORK} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, pp, sum;
    logic [CW-1:0]      cnt;
    logic               last;

    assign last = (cnt == LAST);
    assign pp   = b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0;
    assign sum  = acc + pp;

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    // next state: accept only while idle, leave work on the last bit
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (start ? WORK : IDLE) : (last ? IDLE : WORK);
    end

    // datapath: capture operands on accept, accumulate one bit per clock, publish on the last bit
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            y    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r  <= a;
                    b_r  <= b;
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                if (last) begin
                    y    <= sum;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
endmodule
